// File: rtl/enc_pkg.sv
// Shared definitions for the encoded-lane packer: default lane geometry,
// the one-hot FSM state encoding and the lane index type.
package enc_pkg;

    localparam int LANE_W_DEF = 8;
    localparam int LANES_DEF  = 4;

    // One-hot so an illegal encoding is easy to spot and recover from.
    typedef enum logic [2:0] {
        ST_INIT = 3'b001,
        ST_FILL = 3'b010,
        ST_HOLD = 3'b100
    } state_e;

    typedef logic [$clog2(LANES_DEF)-1:0] lane_idx_t;

endpackage

// File: rtl/enc_lane_packer.sv
// enc_lane_packer: drains the encoded-lane FIFO (first-word-fall-through),
// packs LANES consecutive lanes into one word, and offers it downstream.
// Optional feature macro: ENC_PACK_COUNT_EN adds a 32-bit accepted-word
// counter on output port words_out.
//
// Stream handshake: m_valid is raised with m_data and both hold steady until
// the cycle in which m_ready is also high; the word transfers on that clock
// edge. m_ready is ignored while m_valid is low. Only pack_clr or reset can
// withdraw a word that has not transferred.
module enc_lane_packer
    import enc_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF,
    parameter int LANES  = LANES_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enc_fifo_empty,
    input  logic [LANE_W-1:0]         enc_fifo_dout,
    output logic                      enc_fifo_pop,
    input  logic                      pack_clr,
    output logic [LANES*LANE_W-1:0]   m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      pack_busy,
    output logic [2:0]                state_dbg
`ifdef ENC_PACK_COUNT_EN
    ,
    output logic [31:0]               words_out
`endif
);

    localparam int CNT_W  = $clog2(LANES);
    localparam int WORD_W = LANES * LANE_W;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic [WORD_W-1:0]  lanes_q, lanes_d;
    logic [WORD_W-1:0]  m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d;
    logic               pop_c;

    // Next-state and output logic; reset, then pack_clr, override the FSM.
    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        lanes_d    = lanes_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        pop_c      = 1'b0;

        if (reset) begin
            state_d = ST_INIT;
        end else if (pack_clr) begin
            lane_cnt_d = '0;
            m_valid_d  = 1'b0;
            m_data_d   = '0;
            state_d    = ST_FILL;
        end else begin
            case (state_q)
                ST_INIT: begin
                    lane_cnt_d = '0;
                    m_valid_d  = 1'b0;
                    m_data_d   = '0;
                    state_d    = ST_FILL;
                end
                ST_FILL: begin
                    pop_c = !enc_fifo_empty;
                    if (!enc_fifo_empty) begin
                        // Capture on the popping edge: the FIFO head is
                        // already valid, so there is no extra read cycle.
                        for (int i = 0; i < LANES; i++) begin
                            if (lane_cnt_q == CNT_W'(i)) begin
                                lanes_d[i*LANE_W +: LANE_W] = enc_fifo_dout;
                            end
                        end
                        lane_cnt_d = lane_cnt_q + CNT_W'(1);
                        if (lane_cnt_q == CNT_W'(LANES - 1)) begin
                            m_data_d  = lanes_d;
                            m_valid_d = 1'b1;
                            state_d   = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        m_valid_d = 1'b0;
                        state_d   = ST_FILL;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    // State, lane store and output word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            lane_cnt_q <= '0;
            lanes_q    <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            lanes_q    <= lanes_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign enc_fifo_pop = pop_c;
    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign pack_busy    = (lane_cnt_q != '0) || m_valid_q;
    assign state_dbg    = state_q;

`ifdef ENC_PACK_COUNT_EN
    logic [31:0] words_q, words_d;

    // Count transferred words; a word cleared in its handshake cycle is not counted.
    always_comb begin
        words_d = words_q;
        if (pack_clr) begin
            words_d = '0;
        end else if (m_valid_q && m_ready) begin
            words_d = words_q + 32'd1;
        end
    end

    // Accepted-word counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign words_out = words_q;
`endif

endmodule

// File: doc/enc_lane_packer.md
# enc_lane_packer

Downstream neighbour of the raw-data encode FSM. Drains the encoded-lane FIFO that the FSM fills one lane per cycle (lane order 0..LANES-1). Packs LANES consecutive lane results into one output word and presents it on a valid/ready stream to the next stage, such as the egress/AXI-stream writer. Supports a synchronous clear that is aligned with the encoder's output-FIFO clear.

## Interface
- LANE_W, 8, width of one encoded lane
- LANES, 4, lanes per packed word (power of two, ≥2)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enc_fifo_empty  in  1  encoded-lane FIFO empty (first-word-fall-through)
- enc_fifo_dout  in  LANE_W  head of FIFO, valid when !enc_fifo_empty
- enc_fifo_pop  out  1  consume head at this clock edge
- pack_clr  in  1  drop partial word and outstanding output (driven from encoder's raw_data_out_fifo_clr)
- m_data  out  LANES*LANE_W  packed word, lane i at bits [i*LANE_W +: LANE_W]
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts when m_valid && m_ready
- pack_busy  out  1  partial word held (lane_cnt ≠ 0) or m_valid high

## Operation
- States: INIT, FILL, HOLD.
- INIT: one cycle. lane_cnt←0, m_valid←0, m_data←0. Next state is FILL.
- FILL:
  - enc_fifo_pop = !enc_fifo_empty (combinational).
  - On pop: lane[lane_cnt]←enc_fifo_dout, lane_cnt←lane_cnt+1.
  - When the pop fills lane LANES-1: lane_cnt wraps to 0, m_data←all lanes with the new lane included, m_valid←1, next state is HOLD.
  - If empty: stay in FILL, no pop.
- HOLD:
  - enc_fifo_pop=0. m_data and m_valid stay stable until the handshake.
  - On m_ready: m_valid←0, next state is FILL. No pop in the handshake cycle.
- pack_clr: checked before all state logic.
  - lane_cnt←0, m_valid←0, m_data←0, next state is FILL, enc_fifo_pop forced 0 in that cycle.
  - Any partial or un-accepted word is discarded.
- reset takes priority over pack_clr and returns the block to INIT.
- Illegal state encoding: next state is INIT.
- lane_cnt width is $clog2(LANES). It wraps naturally.

## Timing
- Reset values: enc_fifo_pop=0, m_valid=0, m_data=0, pack_busy=0, state=INIT.
- Pop-to-capture latency is 0: data is sampled on the same edge that pops it.
- Last-lane pop to m_valid high: 1 cycle. m_valid rises on the edge that captures the last lane.
- Best-case throughput: one word per LANES+1 cycles, i.e. LANES pops plus 1 handshake cycle.
- m_valid never drops without the handshake, except on pack_clr or reset. m_data never changes while m_valid=1.
- m_ready while m_valid=0 is ignored.
- FIFO empty mid-word: lane_cnt holds and the partial word is retained indefinitely.
- pack_clr in the same cycle as a handshake: the word counts as discarded. No PACK_CNT increment.

## Configuration
- ENC_PACK_COUNT_EN:
  - Defined: adds output port words_out (32 bits, reset 0). It increments on every m_valid && m_ready, wraps 0xFFFFFFFF→0, and is cleared by pack_clr.
  - Undefined: port absent, no counter logic.

## Structure
- Shared package enc_pkg holds:
  - state encoding constants (one-hot: INIT=3'b001, FILL=3'b010, HOLD=3'b100);
  - the default LANE_W/LANES values;
  - a typedef for the lane index.
- No sub-module. The lane register file and counter are inline. The FSM is one sequential block plus one combinational next-state/output block.

## Test plan
- LANE_W=8, LANES=4. FIFO supplies 0x11,0x22,0x33,0x44 back-to-back with m_ready=1. Expect: pops on 4 consecutive cycles, m_data=0x44332211, m_valid high exactly 1 cycle, pack_busy=0 afterwards.
- m_ready=0 for 10 cycles after m_valid. Expect: m_data stable, enc_fifo_pop=0 throughout, a following 0x55 not popped until the handshake completes.
- FIFO empties after 2 lanes (0xAA,0xBB) and refills 5 cycles later with 0xCC,0xDD. Expect m_data=0xDDCCBBAA.
- pack_clr after 3 lanes are captured, then lanes 0x01..0x04. Expect m_data=0x04030201 with no stale lanes. pack_clr asserted during HOLD: expect m_valid→0 the next cycle.
- reset asserted mid-word and during HOLD. Expect all outputs 0 the next cycle, one INIT cycle with no pop, then normal fill.
- With ENC_PACK_COUNT_EN defined: 3 accepted words gives words_out=3, pack_clr gives 0, and a preload to 0xFFFFFFFF plus one accept wraps to 0.
